// File: rtl/traceback_unit_pkg.sv
// Shared types for the traceback walker: direction codes (which double as the
// path operation encoding), walker states and path-length limits.
package traceback_unit_pkg;

    localparam int MAX_STEPS  = 63;
    localparam int PATH_LEN_W = 6;

    typedef enum logic [1:0] {
        DIR_STOP = 2'b00,
        DIR_DIAG = 2'b01,
        DIR_UP   = 2'b10,
        DIR_LEFT = 2'b11
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_READ = 2'b01,
        ST_EVAL = 2'b10,
        ST_DONE = 2'b11
    } tb_state_e;

endpackage

// File: rtl/traceback_unit.sv
// Walks the score matrix back from the maximum cell, one element per
// READ/EVAL pair, emitting the local alignment path until STOP or a boundary.
module traceback_unit
    import traceback_unit_pkg::*;
#(
    parameter int ROW_BITS_WIDTH = 5,
    parameter int COL_BITS_WIDTH = 5,
    parameter int DIR_W          = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en_traceback,
    input  logic                      start_of_traceback,
    input  logic [ROW_BITS_WIDTH-1:0] max_row,
    input  logic [COL_BITS_WIDTH-1:0] max_col,
    input  logic [DIR_W-1:0]          dir_in,
    output logic [ROW_BITS_WIDTH-1:0] next_row,
    output logic [COL_BITS_WIDTH-1:0] next_col,
    output logic                      finished,
    output logic                      path_valid,
    output logic [1:0]                path_op,
    output logic [ROW_BITS_WIDTH-1:0] path_row,
    output logic [COL_BITS_WIDTH-1:0] path_col,
    output logic [PATH_LEN_W-1:0]     path_len,
    output logic                      tb_busy
);

    // path_valid is a one-cycle qualifier for path_op/path_row/path_col; there
    // is no back-pressure, the consumer must take the element when it is high.
    localparam logic [PATH_LEN_W-1:0] LAST_LEN = PATH_LEN_W'(MAX_STEPS - 1);

    tb_state_e                 state_q, state_d;
    dir_e                      dir;
    logic                      underflow;
    logic [ROW_BITS_WIDTH-1:0] row_d, prow_d;
    logic [COL_BITS_WIDTH-1:0] col_d, pcol_d;
    logic [PATH_LEN_W-1:0]     len_d;
    logic [1:0]                op_d;
    logic                      valid_d, fin_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        row_d     = next_row;
        col_d     = next_col;
        len_d     = path_len;
        op_d      = path_op;
        prow_d    = path_row;
        pcol_d    = path_col;
        valid_d   = 1'b0;
        fin_d     = 1'b0;
        underflow = 1'b0;
        dir       = dir_e'(dir_in[1:0]);
        unique case (state_q)
            ST_IDLE: begin
                if (en_traceback && start_of_traceback) begin
                    row_d   = max_row;
                    col_d   = max_col;
                    len_d   = '0;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                state_d = en_traceback ? ST_EVAL : ST_IDLE;
            end
            ST_EVAL: begin
                if (!en_traceback) begin
                    state_d = ST_IDLE;
                end else if (dir == DIR_STOP) begin
                    fin_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    valid_d = 1'b1;
                    op_d    = dir;
                    prow_d  = next_row;
                    pcol_d  = next_col;
                    len_d   = path_len + PATH_LEN_W'(1);
                    case (dir)
                        DIR_DIAG: underflow = (next_row == '0) || (next_col == '0);
                        DIR_UP:   underflow = (next_row == '0);
                        default:  underflow = (next_col == '0);
                    endcase
                    // A terminating element leaves the coordinates on the last cell.
                    if (underflow || path_len == LAST_LEN) begin
                        fin_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        if (dir != DIR_LEFT) row_d = next_row - ROW_BITS_WIDTH'(1);
                        if (dir != DIR_UP)   col_d = next_col - COL_BITS_WIDTH'(1);
                        state_d = ST_READ;
                    end
                end
            end
            ST_DONE: begin
                if (!en_traceback) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            next_row   <= '0;
            next_col   <= '0;
            path_len   <= '0;
            path_row   <= '0;
            path_col   <= '0;
            path_op    <= '0;
            finished   <= 1'b0;
            path_valid <= 1'b0;
            tb_busy    <= 1'b0;
        end else begin
            next_row   <= row_d;
            next_col   <= col_d;
            path_len   <= len_d;
            path_row   <= prow_d;
            path_col   <= pcol_d;
            path_op    <= op_d;
            finished   <= fin_d;
            path_valid <= valid_d;
            tb_busy    <= (state_d == ST_READ) || (state_d == ST_EVAL);
        end
    end

endmodule

// File: tb/tb_traceback_unit.sv
// Directed and random traceback walks over a bench-held direction matrix,
// compared cycle by cycle with a path model built from the walking rules.
module tb_traceback_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       en_traceback;
    logic       start_of_traceback;
    logic [4:0] max_row, max_col;
    logic [1:0] dir_in;
    logic [4:0] next_row, next_col;
    logic       finished, path_valid;
    logic [1:0] path_op;
    logic [4:0] path_row, path_col;
    logic [5:0] path_len;
    logic       tb_busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0] mem [32][32];

    logic [4:0] exp_row_q [$];
    logic [4:0] exp_col_q [$];
    logic [1:0] exp_op_q  [$];
    logic [4:0] ev_row_q  [$];
    logic [4:0] ev_col_q  [$];
    int         exp_steps, exp_elems;
    int         fin_r, fin_c;

    traceback_unit dut (
        .clk(clk), .rst(rst), .en_traceback(en_traceback),
        .start_of_traceback(start_of_traceback), .max_row(max_row), .max_col(max_col),
        .dir_in(dir_in), .next_row(next_row), .next_col(next_col), .finished(finished),
        .path_valid(path_valid), .path_op(path_op), .path_row(path_row),
        .path_col(path_col), .path_len(path_len), .tb_busy(tb_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_mem();
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++) mem[r][c] = 2'b00;
    endtask

    // Path model: follow directions from the start cell, stopping on STOP,
    // on a move that would leave the matrix, or when 63 elements exist.
    task automatic build_model(input int r0, input int c0);
        int r, c, d;
        exp_row_q.delete(); exp_col_q.delete(); exp_op_q.delete();
        ev_row_q.delete(); ev_col_q.delete();
        r = r0; c = c0; exp_steps = 0; exp_elems = 0;
        while (1) begin
            d = int'(mem[r][c]);
            ev_row_q.push_back(5'(r)); ev_col_q.push_back(5'(c));
            exp_steps++;
            if (d == 0) break;
            exp_row_q.push_back(5'(r)); exp_col_q.push_back(5'(c)); exp_op_q.push_back(2'(d));
            exp_elems++;
            if (exp_elems == 63) break;
            if (d == 1) begin
                if (r == 0 || c == 0) break;
                r--; c--;
            end else if (d == 2) begin
                if (r == 0) break;
                r--;
            end else begin
                if (c == 0) break;
                c--;
            end
        end
        fin_r = r; fin_c = c;
    endtask

    // Cycle c is the negedge after the c-th rising edge following the start pulse.
    task automatic run_walk(input string name, input int r0, input int c0,
                            input bit spur, input int abort_at);
        bit pv_exp;
        build_model(r0, c0);
        @(negedge clk);
        max_row = 5'(r0); max_col = 5'(c0); en_traceback = 1'b1; start_of_traceback = 1'b1;
        @(negedge clk);
        for (int c = 0; c <= 2 * exp_steps + 1; c++) begin
            if (abort_at >= 0 && c == abort_at + 1) begin
                chk($sformatf("%s abort busy", name), 32'(tb_busy), 0);
                chk($sformatf("%s abort finished", name), 32'(finished), 0);
                chk($sformatf("%s abort valid", name), 32'(path_valid), 0);
                @(negedge clk);
                chk($sformatf("%s abort idle busy", name), 32'(tb_busy), 0);
                chk($sformatf("%s abort idle finished", name), 32'(finished), 0);
                return;
            end
            chk($sformatf("%s c%0d busy", name, c), 32'(tb_busy), 32'(c < 2 * exp_steps));
            chk($sformatf("%s c%0d finished", name, c), 32'(finished), 32'(c == 2 * exp_steps));
            pv_exp = (c > 0) && (c % 2 == 0) && (c / 2 <= exp_elems);
            chk($sformatf("%s c%0d valid", name, c), 32'(path_valid), 32'(pv_exp));
            if (pv_exp) begin
                chk($sformatf("%s e%0d op", name, c / 2), 32'(path_op), 32'(exp_op_q[c / 2 - 1]));
                chk($sformatf("%s e%0d row", name, c / 2), 32'(path_row), 32'(exp_row_q[c / 2 - 1]));
                chk($sformatf("%s e%0d col", name, c / 2), 32'(path_col), 32'(exp_col_q[c / 2 - 1]));
                chk($sformatf("%s e%0d len", name, c / 2), 32'(path_len), 32'(c / 2));
            end
            if (c < 2 * exp_steps) begin
                chk($sformatf("%s c%0d next_row", name, c), 32'(next_row), 32'(ev_row_q[c / 2]));
                chk($sformatf("%s c%0d next_col", name, c), 32'(next_col), 32'(ev_col_q[c / 2]));
            end
            dir_in = mem[next_row][next_col];
            max_row = 5'($urandom_range(0, 31));
            max_col = 5'($urandom_range(0, 31));
            start_of_traceback = spur && (c == 0);
            if (abort_at == c) en_traceback = 1'b0;
            @(negedge clk);
        end
        chk($sformatf("%s final len", name), 32'(path_len), 32'(exp_elems));
        chk($sformatf("%s final row", name), 32'(next_row), 32'(fin_r));
        chk($sformatf("%s final col", name), 32'(next_col), 32'(fin_c));
        en_traceback = 1'b0;
        @(negedge clk);
        chk($sformatf("%s idle busy", name), 32'(tb_busy), 0);
        chk($sformatf("%s idle finished", name), 32'(finished), 0);
        chk($sformatf("%s idle valid", name), 32'(path_valid), 0);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, " next_row"}, 32'(next_row), 0);
        chk({name, " next_col"}, 32'(next_col), 0);
        chk({name, " finished"}, 32'(finished), 0);
        chk({name, " path_valid"}, 32'(path_valid), 0);
        chk({name, " path_op"}, 32'(path_op), 0);
        chk({name, " path_row"}, 32'(path_row), 0);
        chk({name, " path_col"}, 32'(path_col), 0);
        chk({name, " path_len"}, 32'(path_len), 0);
        chk({name, " tb_busy"}, 32'(tb_busy), 0);
    endtask

    initial begin
        rst = 1'b1; en_traceback = 1'b0; start_of_traceback = 1'b0;
        max_row = '0; max_col = '0; dir_in = '0;
        #1;
        chk_all_zero("reset");
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        clear_mem();
        mem[3][3] = 2'b01; mem[2][2] = 2'b01; mem[1][1] = 2'b01;
        run_walk("diag", 3, 3, 1'b0, -1);

        clear_mem();
        mem[0][5] = 2'b10;
        run_walk("boundary", 0, 5, 1'b0, -1);

        clear_mem();
        mem[4][2] = 2'b01; mem[3][1] = 2'b11; mem[3][0] = 2'b10;
        run_walk("mixed", 4, 2, 1'b0, -1);

        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++)
                mem[r][c] = (((31 - r) + (31 - c)) % 2 == 0) ? 2'b10 : 2'b11;
        run_walk("maxlen", 31, 31, 1'b0, -1);

        clear_mem();
        mem[3][3] = 2'b01; mem[2][2] = 2'b01; mem[1][1] = 2'b01;
        run_walk("spurious", 3, 3, 1'b1, -1);
        run_walk("abort", 3, 3, 1'b0, 1);
        run_walk("after_abort", 3, 3, 1'b0, -1);

        @(negedge clk);
        max_row = 5'd3; max_col = 5'd3; en_traceback = 1'b1; start_of_traceback = 1'b1;
        @(negedge clk);
        start_of_traceback = 1'b0;
        for (int i = 0; i < 3; i++) begin
            dir_in = mem[next_row][next_col];
            @(negedge clk);
        end
        chk("pre-reset busy", 32'(tb_busy), 1);
        #2 rst = 1'b1;
        #1;
        chk_all_zero("async reset");
        @(negedge clk);
        rst = 1'b0; en_traceback = 1'b0;
        @(negedge clk);

        for (int t = 0; t < 8; t++) begin
            for (int r = 0; r < 32; r++)
                for (int c = 0; c < 32; c++)
                    mem[r][c] = ($urandom_range(0, 11) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            run_walk($sformatf("rand%0d", t), int'($urandom_range(0, 31)),
                     int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
